// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM encoding and default constants for the program-counter generator
package pc_pkg;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int INSTR_GRANULE = 4;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            valid
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx, nxt_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_pop;
  assign top_idx = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
  assign nxt_idx = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign do_pop  = pop && (cnt_q != '0);
  assign valid   = cnt_q != '0;
  assign top     = valid ? mem_q[top_idx] : '0;
  // push+pop rewrites the top in place; a lone push advances ptr and saturates the count
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push && do_pop) begin
      mem_d[top_idx] = push_data;
    end else if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = nxt_idx;
      cnt_d        = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
    end else if (do_pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - 1'b1;
    end
  end
  // stack state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with stall, redirect, trap, halt and optional return-address stack (PC_GEN_RAS_EN)
module pc_gen
  import pc_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int               INSTR_BYTES  = INSTR_GRANULE,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt_req,
  input  logic            resume_req,
  input  logic            call_valid,
  input  logic            ret_valid,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] bad_addr,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            halted
);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, bad_q, bad_d, pc_inc;
  logic            mis_q, mis_d, active, run, aligned;
  assign active       = state_q != BOOT;
  assign run          = state_q == RUN;
  assign aligned      = (redirect_target & ALIGN_MASK) == '0;
  assign pc_inc       = pc_q + STEP;
  assign pc_out       = pc_q;
  assign pc_valid     = run;
  assign halted       = state_q == HALT;
  assign misalign_err = mis_q;
  assign bad_addr     = bad_q;
  // next PC by priority: trap, redirect (misaligned diverts to trap vector), then increment unless stalled or halting
  always_comb begin
    mis_d   = active && redirect_valid && !trap_valid && !aligned;
    bad_d   = mis_d ? redirect_target : bad_q;
    pc_d    = !active                          ? pc_q :
              trap_valid                       ? trap_vector :
              redirect_valid                   ? (aligned ? redirect_target : trap_vector) :
              (run && fetch_ready && !halt_req) ? pc_inc : pc_q;
    state_d = (state_q == BOOT) ? RUN :
              run               ? (halt_req ? HALT : RUN) :
              halted            ? ((trap_valid || resume_req) ? RUN : HALT) : BOOT;
  end
  // control and address registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      bad_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
      mis_q   <= mis_d;
    end
  end
`ifdef PC_GEN_RAS_EN
  pc_ras #(
    .XLEN (XLEN),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (run && call_valid),
    .pop      (run && ret_valid),
    .push_data(pc_inc),
    .top      (ras_top),
    .valid    (ras_valid)
  );
`else
  logic unused_ras;
  assign unused_ras = call_valid ^ ret_valid ^ (RAS_DEPTH > 0);
  assign ras_top    = '0;
  assign ras_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen (RAS expectations follow PC_GEN_RAS_EN)
module tb_pc_gen;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        h;
    logic        m;
    logic [31:0] bad;
    logic [31:0] rtop;
    logic        rv;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b1;
  logic        fetch_ready = 1'b0, redirect_valid = 1'b0, trap_valid = 1'b0;
  logic        halt_req = 1'b0, resume_req = 1'b0, call_valid = 1'b0, ret_valid = 1'b0;
  logic [31:0] redirect_target = '0, trap_vector = 32'h80;
  logic [31:0] pc_out, bad_addr, ras_top;
  logic        pc_valid, misalign_err, ras_valid, halted;
  exp_t        sb[$];
  int          n_total = 0, n_bad = 0, step_no = 0;
  pc_gen #(
    .XLEN        (32),
    .RESET_VECTOR(32'h100),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .call_valid     (call_valid),
    .ret_valid      (ret_valid),
    .pc_out         (pc_out),
    .pc_valid       (pc_valid),
    .misalign_err   (misalign_err),
    .bad_addr       (bad_addr),
    .ras_top        (ras_top),
    .ras_valid      (ras_valid),
    .halted         (halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d got=%h exp=%h", tag, step_no, got, exp);
    end
  endtask
  task automatic drive(input logic fr, input logic rv, input logic [31:0] rt, input logic tv,
                       input logic h, input logic r, input logic c, input logic rr);
    fetch_ready = fr; redirect_valid = rv; redirect_target = rt; trap_valid = tv;
    halt_req = h; resume_req = r; call_valid = c; ret_valid = rr;
  endtask
  task automatic step(input logic [31:0] pc, input logic v, input logic h, input logic m,
                      input logic [31:0] bad, input logic [31:0] rtop, input logic rv);
    exp_t e;
    sb.push_back('{pc, v, h, m, bad, RAS ? rtop : 32'h0, RAS ? rv : 1'b0});
    @(posedge clk);
    #1;
    step_no++;
    e = sb.pop_front();
    chk("pc_out", pc_out, e.pc);
    chk("pc_valid", {31'b0, pc_valid}, {31'b0, e.v});
    chk("halted", {31'b0, halted}, {31'b0, e.h});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, e.m});
    chk("bad_addr", bad_addr, e.bad);
    chk("ras_top", ras_top, e.rtop);
    chk("ras_valid", {31'b0, ras_valid}, {31'b0, e.rv});
  endtask
  task automatic check_reset_values();
    chk("rst_pc", pc_out, 32'h100);
    chk("rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_mis", {31'b0, misalign_err}, 32'h0);
    chk("rst_bad", bad_addr, 32'h0);
    chk("rst_ras_top", ras_top, 32'h0);
    chk("rst_ras_valid", {31'b0, ras_valid}, 32'h0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;
    check_reset_values();
    drive(1, 0, 0, 0, 0, 0, 0, 0); step(32'h100, 1, 0, 0, 0, 0, 0);
    step(32'h104, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(32'h104, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0); step(32'h108, 1, 0, 0, 0, 0, 0);
    step(32'h10c, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h2000, 0, 0, 0, 0, 0); step(32'h2000, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h3000, 1, 0, 0, 0, 0); step(32'h80, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h2002, 0, 0, 0, 0, 0); step(32'h80, 1, 0, 1, 32'h2002, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step(32'h80, 1, 0, 0, 32'h2002, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0); step(32'h80, 0, 1, 0, 32'h2002, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0); step(32'h80, 0, 1, 0, 32'h2002, 0, 0);
    drive(1, 0, 0, 0, 1, 1, 0, 0); step(32'h80, 1, 0, 0, 32'h2002, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0); step(32'h84, 1, 0, 0, 32'h2002, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0); step(32'h84, 0, 1, 0, 32'h2002, 0, 0);
    drive(0, 1, 32'h400, 0, 0, 0, 0, 0); step(32'h400, 0, 1, 0, 32'h2002, 0, 0);
    drive(0, 1, 32'h401, 0, 0, 0, 0, 0); step(32'h80, 0, 1, 1, 32'h401, 0, 0);
    trap_vector = 32'hc0;
    drive(0, 0, 0, 1, 0, 0, 0, 0); step(32'hc0, 1, 0, 0, 32'h401, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0); step(32'hc4, 1, 0, 0, 32'h401, 0, 0);
    drive(1, 1, 32'hffff_fffc, 0, 0, 0, 0, 0); step(32'hffff_fffc, 1, 0, 0, 32'h401, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0); step(32'h0, 1, 0, 0, 32'h401, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0); step(32'h100, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h10, 0, 0, 0, 0, 0); step(32'h10, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h20, 0, 0, 0, 1, 0); step(32'h20, 1, 0, 0, 0, 32'h14, 1);
    drive(0, 1, 32'h30, 0, 0, 0, 1, 0); step(32'h30, 1, 0, 0, 0, 32'h24, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0); step(32'h30, 1, 0, 0, 0, 32'h34, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1); step(32'h30, 1, 0, 0, 0, 32'h24, 1);
    step(32'h30, 1, 0, 0, 0, 32'h0, 0);
    step(32'h30, 1, 0, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the plain PC register.
- Adds reset vector, fetch stall, redirect, trap entry, halt/resume and misaligned-target detection.
- Sits at the head of the fetch stage: drives instruction-memory address and fetch-valid; takes redirects from branch/jump resolution and traps from control.

Parameters:
- XLEN, 32, PC/address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment and alignment granule; power of two.
- RAS_DEPTH, 4, return-address-stack entries; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_ready  in  1  fetch stage accepts current pc_out this cycle.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  XLEN  redirect destination.
- trap_valid  in  1  exception/interrupt entry request.
- trap_vector  in  XLEN  trap handler address; must be aligned.
- halt_req  in  1  request halt.
- resume_req  in  1  leave HALT.
- call_valid  in  1  current instruction is a call (RAS push).
- ret_valid  in  1  current instruction is a return (RAS pop).
- pc_out  out  XLEN  current fetch address.
- pc_valid  out  1  pc_out is a valid fetch request.
- misalign_err  out  1  one-cycle pulse: rejected misaligned redirect.
- bad_addr  out  XLEN  last rejected redirect target.
- ras_top  out  XLEN  predicted return address.
- ras_valid  out  1  RAS non-empty.
- halted  out  1  FSM in HALT.

Behaviour:
- Reset (async assert, sync release): pc_out=RESET_VECTOR, pc_valid=0, state=BOOT, misalign_err=0, bad_addr=0, halted=0, ras_valid=0, ras_top=0, RAS pointer=0.
- FSM states:
  - BOOT: pc_valid=0. Unconditionally moves to RUN after one cycle; pc_out is unchanged.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0, halted=1.
- All updates are registered. An event sampled on edge N is visible on pc_out after edge N; redirect latency is 1 cycle.
- RUN next-PC priority, highest first:
  1. trap_valid: pc_out<=trap_vector.
  2. redirect_valid, aligned target: pc_out<=redirect_target.
  3. redirect_valid, misaligned target (target mod INSTR_BYTES != 0): pc_out<=trap_vector, bad_addr<=target, misalign_err=1 for one cycle.
  4. !fetch_ready: hold pc_out.
  5. Otherwise: pc_out<=pc_out+INSTR_BYTES, modulo 2^XLEN; all-ones granule wraps to 0.
- Redirect and trap are honoured even when fetch_ready=0; the stall only blocks sequential increment.
- halt_req in RUN: enter HALT next cycle. A same-cycle redirect or trap is still applied to pc_out.
- HALT:
  - resume_req: go to RUN, pc_out held.
  - trap_valid: load trap_vector and go to RUN; trap wakes the core.
  - redirect_valid: load target, stay in HALT; misaligned target is handled as in RUN, stay in HALT.
  - halt_req and resume_req together: resume wins.
- BOOT ignores all requests except reset.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro PC_GEN_RAS_EN.
- Defined:
  - RAS_DEPTH-entry circular stack.
  - call_valid pushes pc_out+INSTR_BYTES; ret_valid pops.
  - ras_top = top entry; ras_valid = count>0.
  - Push when full overwrites the oldest entry; pop when empty is ignored.
  - Simultaneous push and pop replaces the top; count unchanged.
  - Trap clears nothing. Reset empties the stack.
- Undefined: call_valid and ret_valid are ignored; ras_top=0, ras_valid=0; no stack storage.
- The stack is a prediction aid only; pc_out changes only via redirect.

Decomposition:
- Shared package pc_pkg:
  - FSM state typedef {BOOT, RUN, HALT}, 2 bits.
  - Default RESET_VECTOR constant.
  - Instruction-granule constant.
- One natural sub-module: pc_ras, the return address stack, instantiated only under PC_GEN_RAS_EN.

Test Plan:
- Reset with RESET_VECTOR=0x100, then release → one BOOT cycle with pc_valid=0 → pc 0x100, 0x104, 0x108 with pc_valid=1 while fetch_ready=1.
- fetch_ready=0 for 3 cycles at pc 0x104 → pc_out holds 0x104; resumes at 0x108 when fetch_ready=1.
- redirect_valid with target 0x2000 and fetch_ready=0 → pc_out=0x2000 next cycle. Same cycle with trap_valid and trap_vector=0x80 → pc_out=0x80.
- redirect target 0x2002 → pc_out=trap_vector, misalign_err pulses 1 cycle, bad_addr=0x2002.
- halt_req → halted=1 and pc_valid=0 with pc held; resume_req → RUN with same pc. Trap while halted → pc=trap_vector, RUN.
- PC_GEN_RAS_EN, RAS_DEPTH=2, pc_out at 0x10, 0x20, 0x30 in turn: call_valid at each → ras_top=0x34, oldest entry 0x14 dropped; pop twice → ras_top=0x24 then ras_valid=0.
